wb_rr_arbiter: RTL

Round-robin arbiter that shares one Wishbone slave port between NUM_MASTERS Wishbone masters, for example the ahb2wb bridge and a DMA engine. It sequences bus ownership at cycle granularity: one master owns the slave for the whole of its cyc assertion. It muxes the address, data and control lines from the owner to the slave. It routes the slave's ack back to the owner only.

---
 rtl/wb_arb_pkg.sv | 19 +
 rtl/wb_rr_pick.sv | 29 ++
 rtl/wb_rr_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared encodings and sizing helpers for the Wishbone round-robin arbiter.
package wb_arb_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Stall counter has to be able to hold the value TIMEOUT itself.
  function automatic int stall_w(input int timeout);
    return clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Rotating priority encoder: first requester above 'last', wrapping around.
module wb_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic [IW-1:0] k;
    logic          found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 1; i <= N; i++) begin
      k = IW'((int'(last) + i) % N);
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among NUM_MASTERS masters.
// Define WB_ARB_TIMEOUT_EN to add the stall timeout with m_err_o reporting.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int AWIDTH      = 16,
  parameter int DWIDTH      = 32,
  parameter int TIMEOUT     = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*AWIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DWIDTH-1:0] m_dat_i,
  output logic [DWIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [NUM_MASTERS-1:0]        gnt_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic                          s_we_o,
  output logic [AWIDTH-1:0]             s_adr_o,
  output logic [DWIDTH-1:0]             s_dat_o,
  input  logic [DWIDTH-1:0]             s_dat_i,
  input  logic                          s_ack_i
);

  localparam int IW = clog2(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 4) begin : g_bad_masters
    $error("wb_rr_arbiter: NUM_MASTERS must be in 2..4");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("wb_rr_arbiter: TIMEOUT must be at least 1");
  end

  logic [0:0]                         state;
  logic [IW-1:0]                      last;
  logic [IW-1:0]                      pick_idx;
  logic [NUM_MASTERS-1:0]             pick_gnt;
  logic                               own;
  logic                               timeout;
  logic                               rel;
  logic [NUM_MASTERS-1:0][AWIDTH-1:0] adr_v;
  logic [NUM_MASTERS-1:0][DWIDTH-1:0] dat_v;

  assign adr_v = m_adr_i;
  assign dat_v = m_dat_i;

  wb_rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
    .req  (m_cyc_i),
    .last (last),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  // 'last' doubles as the owner index while in OWN.
  assign own     = (state == ST_OWN);
  assign s_cyc_o = own & m_cyc_i[last];
  assign s_stb_o = own & m_stb_i[last];
  assign s_we_o  = own & m_we_i[last];
  assign s_adr_o = own ? adr_v[last] : '0;
  assign s_dat_o = own ? dat_v[last] : '0;
  assign m_ack_o = own ? (gnt_o & {NUM_MASTERS{s_ack_i}}) : '0;
  assign m_dat_o = s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = stall_w(TIMEOUT);
  logic [CW-1:0] stall;

  assign timeout = own && (stall == CW'(TIMEOUT));
  assign m_err_o = timeout ? gnt_o : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i || s_ack_i || !s_stb_o || timeout) stall <= '0;
    else                                         stall <= stall + CW'(1);
  end
`else
  assign timeout = 1'b0;
  assign m_err_o = '0;
`endif

  assign rel = !m_cyc_i[last] || timeout;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      gnt_o <= '0;
      last  <= IW'(NUM_MASTERS - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (|m_cyc_i) begin
            state <= ST_OWN;
            gnt_o <= pick_gnt;
            last  <= pick_idx;
          end
        end
        default: begin
          if (rel) begin
            state <= ST_IDLE;
            gnt_o <= '0;
          end
        end
      endcase
    end
  end

endmodule
